// File: rtl/rat_cu_pkg.sv
// rtl/rat_cu_pkg.sv - RAT control unit states, opcodes, select codes and control bundle
package rat_cu_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    // Opcode families matched on the upper five bits only
    localparam logic [4:0] OPH_IN  = 5'b11001;
    localparam logic [4:0] OPH_OUT = 5'b11010;
    localparam logic [4:0] OPH_MOV = 5'b11011;

    localparam logic [6:0] OP_EXOR  = 7'b0000010;
    localparam logic [6:0] OP_BRN   = 7'b0010000;
    localparam logic [6:0] OP_CALL  = 7'b0010001;
    localparam logic [6:0] OP_BREQ  = 7'b0010010;
    localparam logic [6:0] OP_BRNE  = 7'b0010011;
    localparam logic [6:0] OP_BRCS  = 7'b0010100;
    localparam logic [6:0] OP_BRCC  = 7'b0010101;
    localparam logic [6:0] OP_RET   = 7'b0110010;
    localparam logic [6:0] OP_SEI   = 7'b0110100;
    localparam logic [6:0] OP_CLI   = 7'b0110101;
    localparam logic [6:0] OP_RETID = 7'b0110110;
    localparam logic [6:0] OP_RETIE = 7'b0110111;

    localparam logic [3:0] ALU_EXOR = 4'd7;
    localparam logic [3:0] ALU_MOV  = 4'd14;

    localparam logic [1:0] PC_SEL_IMM      = 2'd0;
    localparam logic [1:0] PC_SEL_STACK    = 2'd1;
    localparam logic [1:0] RF_SEL_ALU      = 2'd0;
    localparam logic [1:0] RF_SEL_IN       = 2'd3;
    localparam logic [1:0] SCR_ADDR_SP     = 2'd2;
    localparam logic [1:0] SCR_ADDR_SP_DEC = 2'd3;
    localparam logic       SCR_DATA_PC     = 1'b1;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] pc_mux_sel;
        logic       rf_wr;
        logic [1:0] rf_wr_sel;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       scr_we;
        logic [1:0] scr_addr_sel;
        logic       scr_data_sel;
        logic       sp_incr;
        logic       sp_decr;
        logic       flg_c_ld;
        logic       flg_z_ld;
        logic       flg_ld_sel;
        logic       flg_shad_ld;
        logic       i_set;
        logic       i_clr;
        logic       io_strb;
        logic       rst;
    } cu_ctl_t;

endpackage

// File: rtl/rat_fetch_timer.sv
// rtl/rat_fetch_timer.sv - fetch wait-state counter and interrupt pending latch
module rat_fetch_timer
    import rat_cu_pkg::*;
#(
    parameter int FETCH_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_fetch,
    input  logic int_req,
    input  logic intr_entry,
    output logic fetch_done,
    output logic int_pending
);

    localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT);

    logic [1:0] wait_q, wait_d;
    logic       pend_q, pend_d;

    // Counter idles at zero outside fetch, so the compare is only meaningful in ST_FETCH
    assign fetch_done  = (wait_q == WAIT_LAST);
    assign int_pending = pend_q;

    always_comb begin
        wait_d = 2'd0;
        if (in_fetch && !fetch_done) begin
            wait_d = wait_q + 2'd1;
        end
        // A request arriving on the clearing cycle must not be lost
        pend_d = int_req | (pend_q & ~intr_entry);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= 2'd0;
            pend_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/rat_cu_intr.sv
// rtl/rat_cu_intr.sv - RAT multicycle control unit with wait-state fetch and interrupts
module rat_cu_intr
    import rat_cu_pkg::*;
#(
    parameter int         FETCH_WAIT     = 0,
    parameter logic [1:0] INT_VECTOR_SEL = 2'd2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] OPCODE_HI_5,
    input  logic [1:0] OPCODE_LOW_2,
    input  logic       INT,
    input  logic       C_FLAG,
    input  logic       Z_FLAG,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       RF_WR,
    output logic [1:0] RF_WR_SEL,
    output logic       ALU_OPY_SEL,
    output logic [3:0] ALU_SEL,
    output logic       SCR_WE,
    output logic [1:0] SCR_ADDR_SEL,
    output logic       SCR_DATA_SEL,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       FLG_C_LD,
    output logic       FLG_Z_LD,
    output logic       FLG_LD_SEL,
    output logic       FLG_SHAD_LD,
    output logic       I_SET,
    output logic       I_CLR,
    output logic       IO_STRB,
    output logic       RST
);

    state_t     state_q, state_d;
    cu_ctl_t    ctl, ctl_out;
    logic [6:0] opcode;
    logic       br_take;
    logic       fetch_done, int_pending, intr_entry;

    assign opcode     = {OPCODE_HI_5, OPCODE_LOW_2};
    assign intr_entry = (state_q == ST_EXEC) && int_pending;

    rat_fetch_timer #(.FETCH_WAIT(FETCH_WAIT)) u_timer (
        .clk        (CLK),
        .reset      (RESET),
        .in_fetch   (state_q == ST_FETCH),
        .int_req    (INT),
        .intr_entry (intr_entry),
        .fetch_done (fetch_done),
        .int_pending(int_pending)
    );

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        br_take = 1'b0;
        case (state_q)
            ST_INIT: begin
                ctl.rst = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_done) begin
                    ctl.pc_inc = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = int_pending ? ST_INTR : ST_FETCH;
                if (OPCODE_HI_5 == OPH_IN) begin
                    ctl.rf_wr     = 1'b1;
                    ctl.rf_wr_sel = RF_SEL_IN;
                end else if (OPCODE_HI_5 == OPH_MOV) begin
                    ctl.rf_wr       = 1'b1;
                    ctl.alu_opy_sel = 1'b1;
                    ctl.alu_sel     = ALU_MOV;
                end else if (OPCODE_HI_5 == OPH_OUT) begin
                    ctl.io_strb = 1'b1;
                end else begin
                    case (opcode)
                        OP_EXOR: begin
                            ctl.rf_wr     = 1'b1;
                            ctl.rf_wr_sel = RF_SEL_ALU;
                            ctl.alu_sel   = ALU_EXOR;
                            ctl.flg_z_ld  = 1'b1;
                            ctl.flg_c_ld  = 1'b1;
                        end
                        OP_BRN:  br_take = 1'b1;
                        OP_BREQ: br_take = Z_FLAG;
                        OP_BRNE: br_take = !Z_FLAG;
                        OP_BRCS: br_take = C_FLAG;
                        OP_BRCC: br_take = !C_FLAG;
                        OP_CALL: begin
                            ctl.pc_ld        = 1'b1;
                            ctl.pc_mux_sel   = PC_SEL_IMM;
                            ctl.sp_decr      = 1'b1;
                            ctl.scr_we       = 1'b1;
                            ctl.scr_data_sel = SCR_DATA_PC;
                            ctl.scr_addr_sel = SCR_ADDR_SP_DEC;
                        end
                        OP_RET, OP_RETID, OP_RETIE: begin
                            ctl.pc_ld        = 1'b1;
                            ctl.pc_mux_sel   = PC_SEL_STACK;
                            ctl.sp_incr      = 1'b1;
                            ctl.scr_addr_sel = SCR_ADDR_SP;
                            if (opcode != OP_RET) begin
                                ctl.flg_ld_sel = 1'b1;
                                ctl.flg_c_ld   = 1'b1;
                                ctl.flg_z_ld   = 1'b1;
                                ctl.i_clr      = (opcode == OP_RETID);
                                ctl.i_set      = (opcode == OP_RETIE);
                            end
                        end
                        OP_SEI:  ctl.i_set = 1'b1;
                        OP_CLI:  ctl.i_clr = 1'b1;
                        default: ;
                    endcase
                    if (br_take) begin
                        ctl.pc_ld      = 1'b1;
                        ctl.pc_mux_sel = PC_SEL_IMM;
                    end
                end
            end
            ST_INTR: begin
                ctl.pc_ld        = 1'b1;
                ctl.pc_mux_sel   = INT_VECTOR_SEL;
                ctl.sp_decr      = 1'b1;
                ctl.scr_we       = 1'b1;
                ctl.scr_data_sel = SCR_DATA_PC;
                ctl.scr_addr_sel = SCR_ADDR_SP_DEC;
                ctl.flg_shad_ld  = 1'b1;
                ctl.i_clr        = 1'b1;
                state_d          = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath stays quiet while reset is held; RST pulses only in the ST_INIT cycle after release
    assign ctl_out = RESET ? '0 : ctl;

    assign PC_LD        = ctl_out.pc_ld;
    assign PC_INC       = ctl_out.pc_inc;
    assign PC_MUX_SEL   = ctl_out.pc_mux_sel;
    assign RF_WR        = ctl_out.rf_wr;
    assign RF_WR_SEL    = ctl_out.rf_wr_sel;
    assign ALU_OPY_SEL  = ctl_out.alu_opy_sel;
    assign ALU_SEL      = ctl_out.alu_sel;
    assign SCR_WE       = ctl_out.scr_we;
    assign SCR_ADDR_SEL = ctl_out.scr_addr_sel;
    assign SCR_DATA_SEL = ctl_out.scr_data_sel;
    assign SP_INCR      = ctl_out.sp_incr;
    assign SP_DECR      = ctl_out.sp_decr;
    assign FLG_C_LD     = ctl_out.flg_c_ld;
    assign FLG_Z_LD     = ctl_out.flg_z_ld;
    assign FLG_LD_SEL   = ctl_out.flg_ld_sel;
    assign FLG_SHAD_LD  = ctl_out.flg_shad_ld;
    assign I_SET        = ctl_out.i_set;
    assign I_CLR        = ctl_out.i_clr;
    assign IO_STRB      = ctl_out.io_strb;
    assign RST          = ctl_out.rst;

endmodule

// File: tb/tb_rat_cu_intr.sv
// tb/tb_rat_cu_intr.sv - randomized scoreboard bench for rat_cu_intr at FETCH_WAIT 0 and 2
module tb_rat_cu_intr;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] pc_mux_sel;
        logic       rf_wr;
        logic [1:0] rf_wr_sel;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       scr_we;
        logic [1:0] scr_addr_sel;
        logic       scr_data_sel;
        logic       sp_incr;
        logic       sp_decr;
        logic       flg_c_ld;
        logic       flg_z_ld;
        logic       flg_ld_sel;
        logic       flg_shad_ld;
        logic       i_set;
        logic       i_clr;
        logic       io_strb;
        logic       rst;
    } outs_t;

    localparam int NUM_INSTR = 200;

    logic             clk;
    logic [1:0]       rst_i, int_i, c_i, z_i;
    logic [1:0][4:0]  hi_i;
    logic [1:0][1:0]  lo_i;
    logic [1:0][25:0] act_bits;

    outs_t exp_q0[$];
    outs_t exp_q1[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    logic [6:0] dir_op [7] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1101100,
                               7'b0010010, 7'b0010010, 7'b0000010};
    logic       dir_z  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int FW = (g == 0) ? 0 : 2;
        logic       pc_ld, pc_inc, rf_wr, alu_opy_sel, scr_we, scr_data_sel;
        logic       sp_incr, sp_decr, flg_c_ld, flg_z_ld, flg_ld_sel, flg_shad_ld;
        logic       i_set, i_clr, io_strb, rst;
        logic [1:0] pc_mux_sel, rf_wr_sel, scr_addr_sel;
        logic [3:0] alu_sel;

        rat_cu_intr #(.FETCH_WAIT(FW), .INT_VECTOR_SEL(2'd2)) u_dut (
            .CLK         (clk),
            .RESET       (rst_i[g]),
            .OPCODE_HI_5 (hi_i[g]),
            .OPCODE_LOW_2(lo_i[g]),
            .INT         (int_i[g]),
            .C_FLAG      (c_i[g]),
            .Z_FLAG      (z_i[g]),
            .PC_LD       (pc_ld),
            .PC_INC      (pc_inc),
            .PC_MUX_SEL  (pc_mux_sel),
            .RF_WR       (rf_wr),
            .RF_WR_SEL   (rf_wr_sel),
            .ALU_OPY_SEL (alu_opy_sel),
            .ALU_SEL     (alu_sel),
            .SCR_WE      (scr_we),
            .SCR_ADDR_SEL(scr_addr_sel),
            .SCR_DATA_SEL(scr_data_sel),
            .SP_INCR     (sp_incr),
            .SP_DECR     (sp_decr),
            .FLG_C_LD    (flg_c_ld),
            .FLG_Z_LD    (flg_z_ld),
            .FLG_LD_SEL  (flg_ld_sel),
            .FLG_SHAD_LD (flg_shad_ld),
            .I_SET       (i_set),
            .I_CLR       (i_clr),
            .IO_STRB     (io_strb),
            .RST         (rst)
        );

        assign act_bits[g] = {pc_ld, pc_inc, pc_mux_sel, rf_wr, rf_wr_sel, alu_opy_sel,
                              alu_sel, scr_we, scr_addr_sel, scr_data_sel, sp_incr,
                              sp_decr, flg_c_ld, flg_z_ld, flg_ld_sel, flg_shad_ld,
                              i_set, i_clr, io_strb, rst};
    end

    // Instruction-set reference: what the exec cycle of each instruction should assert
    function automatic outs_t exec_model(input logic [6:0] op, input logic c, input logic z);
        outs_t o;
        logic  jump;
        logic  ret;
        o    = '0;
        jump = 1'b0;
        ret  = 1'b0;
        if (op[6:2] == 5'b11001) begin
            o.rf_wr     = 1'b1;
            o.rf_wr_sel = 2'd3;
        end else if (op[6:2] == 5'b11011) begin
            o.rf_wr       = 1'b1;
            o.alu_opy_sel = 1'b1;
            o.alu_sel     = 4'd14;
        end else if (op[6:2] == 5'b11010) begin
            o.io_strb = 1'b1;
        end else begin
            case (op)
                7'b0000010: begin
                    o.rf_wr    = 1'b1;
                    o.alu_sel  = 4'd7;
                    o.flg_z_ld = 1'b1;
                    o.flg_c_ld = 1'b1;
                end
                7'b0010000: jump = 1'b1;
                7'b0010010: jump = z;
                7'b0010011: jump = !z;
                7'b0010100: jump = c;
                7'b0010101: jump = !c;
                7'b0010001: begin
                    o.pc_ld        = 1'b1;
                    o.sp_decr      = 1'b1;
                    o.scr_we       = 1'b1;
                    o.scr_data_sel = 1'b1;
                    o.scr_addr_sel = 2'd3;
                end
                7'b0110010: ret = 1'b1;
                7'b0110100: o.i_set = 1'b1;
                7'b0110101: o.i_clr = 1'b1;
                7'b0110110: begin
                    ret = 1'b1;
                    o.flg_ld_sel = 1'b1; o.flg_c_ld = 1'b1; o.flg_z_ld = 1'b1; o.i_clr = 1'b1;
                end
                7'b0110111: begin
                    ret = 1'b1;
                    o.flg_ld_sel = 1'b1; o.flg_c_ld = 1'b1; o.flg_z_ld = 1'b1; o.i_set = 1'b1;
                end
                default: ;
            endcase
        end
        if (jump) o.pc_ld = 1'b1;
        if (ret) begin
            o.pc_ld        = 1'b1;
            o.pc_mux_sel   = 2'd1;
            o.sp_incr      = 1'b1;
            o.scr_addr_sel = 2'd2;
        end
        return o;
    endfunction

    function automatic outs_t intr_model();
        outs_t o;
        o              = '0;
        o.pc_ld        = 1'b1;
        o.pc_mux_sel   = 2'd2;
        o.sp_decr      = 1'b1;
        o.scr_we       = 1'b1;
        o.scr_data_sel = 1'b1;
        o.scr_addr_sel = 2'd3;
        o.flg_shad_ld  = 1'b1;
        o.i_clr        = 1'b1;
        return o;
    endfunction

    function automatic logic [6:0] pick_op();
        logic [1:0] lo;
        lo = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 17))
            0:  return {5'b11001, lo};
            1:  return {5'b11010, lo};
            2:  return {5'b11011, lo};
            3:  return 7'b0000010;
            4:  return 7'b0010000;
            5:  return 7'b0010010;
            6:  return 7'b0010011;
            7:  return 7'b0010100;
            8:  return 7'b0010101;
            9:  return 7'b0010001;
            10: return 7'b0110010;
            11: return 7'b0110100;
            12: return 7'b0110101;
            13: return 7'b0110110;
            14: return 7'b0110111;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    function automatic logic rnd_int();
        return ($urandom_range(0, 7) == 0);
    endfunction

    task automatic drive(input int d, input logic rst, input logic irq, input logic [6:0] op,
                         input logic c, input logic z, input outs_t e);
        @(posedge clk);
        #1;
        rst_i[d] = rst;
        int_i[d] = irq;
        hi_i[d]  = op[6:2];
        lo_i[d]  = op[1:0];
        c_i[d]   = c;
        z_i[d]   = z;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic run(input int d, input int fw);
        outs_t      e;
        outs_t      init_e;
        logic [6:0] op;
        logic       c, z, irq, pend, take, directed;
        int         n_intr;
        init_e     = '0;
        init_e.rst = 1'b1;
        n_intr     = 0;
        drive(d, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, '0);
        drive(d, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, '0);
        drive(d, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, init_e);
        pend = 1'b0;
        for (int n = 0; n < NUM_INSTR; n++) begin
            directed = (n < 7);
            if (directed) begin
                op = dir_op[n];
                c  = 1'b0;
                z  = dir_z[n];
            end else begin
                op = pick_op();
                c  = 1'($urandom_range(0, 1));
                z  = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i <= fw; i++) begin
                irq      = directed ? (n == 6 && i == 0) : rnd_int();
                e        = '0;
                e.pc_inc = (i == fw);
                drive(d, 1'b0, irq, op, c, z, e);
                pend = pend | irq;
            end
            irq  = directed ? 1'b0 : rnd_int();
            take = pend;
            drive(d, 1'b0, irq, op, c, z, exec_model(op, c, z));
            pend = irq | (pend & ~take);
            if (take) begin
                n_intr++;
                if (n_intr == 2 || $urandom_range(0, 3) == 0) begin
                    drive(d, 1'b1, 1'b0, op, c, z, '0);
                    irq = directed ? 1'b0 : rnd_int();
                    drive(d, 1'b0, irq, op, c, z, init_e);
                    pend = irq;
                end else begin
                    irq = directed ? 1'b0 : rnd_int();
                    drive(d, 1'b0, irq, op, c, z, intr_model());
                    pend = pend | irq;
                end
            end
        end
    endtask

    task automatic cmp(input int d, input outs_t e);
        outs_t a;
        a = outs_t'(act_bits[d]);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL dut%0d_outputs cycle %0d: actual %h required %h", d, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q0.size() != 0) cmp(0, exp_q0.pop_front());
        if (exp_q1.size() != 0) cmp(1, exp_q1.pop_front());
    end

    initial begin
        rst_i = 2'b11;
        int_i = 2'b00;
        c_i   = 2'b00;
        z_i   = 2'b00;
        hi_i  = '0;
        lo_i  = '0;
        fork
            run(0, 0);
            run(1, 2);
        join
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: actual %0d pending required 0",
                     exp_q0.size() + exp_q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
